// File: rtl/lookahead_limiter_pkg.sv
// Shared types and helpers for the lookahead peak limiter.
package limiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        HOLD,
        RELEASE
    } lim_state_t;

    localparam logic [8:0] GAIN_UNITY = 9'd256;

    // Magnitude of a signed 16-bit sample; -32768 saturates to 32767.
    function automatic logic [15:0] sat_abs16(input logic [15:0] x);
        if (x == 16'h8000) begin
            return 16'h7fff;
        end else if (x[15]) begin
            return ~x + 16'd1;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/lookahead_limiter_ram.sv
// Circular read-before-write delay RAM; rd_data is the oldest word, or 0 until the line has filled once.
module delay_line_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      fill;

    assign full    = (fill == (AW + 1)'(DEPTH));
    assign rd_data = full ? mem[wr_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!full) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lookahead_limiter.sv
// Lookahead peak limiter: gain reacts to the live sample and is applied to a DELAY_LEN-delayed copy.
// Optional macro LIMITER_HARD_CLIP_EN clamps the limited output to +/-THRESHOLD.
module lookahead_limiter
    import limiter_pkg::*;
#(
    parameter int                 DELAY_LEN    = 16,
    parameter logic signed [15:0] THRESHOLD    = 16'sd24000,
    parameter logic [8:0]         ATTACK_STEP  = 9'd16,
    parameter logic [8:0]         RELEASE_STEP = 9'd2,
    parameter int                 HOLD_SAMPLES = 32,
    parameter logic [8:0]         MIN_GAIN     = 9'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [15:0] in_sample,
    output logic        out_valid,
    output logic [15:0] out_sample,
    output logic [8:0]  gain_out,
    output logic        limiting
);

    localparam int HW = $clog2(HOLD_SAMPLES) + 1;

    lim_state_t          state, state_n;
    logic [8:0]          gain, gain_n, gain_dn, gain_up;
    logic [HW-1:0]       hold_cnt, hold_n;
    logic [15:0]         delayed;
    logic                peak;
    logic signed [25:0]  prod;
    logic [15:0]         scaled;
    logic [15:0]         limited;

    delay_line_ram #(
        .DEPTH (DELAY_LEN),
        .WIDTH (16)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_sample),
        .rd_data (delayed),
        .full    ()
    );

    assign peak     = $signed(sat_abs16(in_sample)) > THRESHOLD;
    assign prod     = $signed(delayed) * $signed({1'b0, gain});
    assign scaled   = 16'(prod >>> 8);
    assign gain_out = gain;

    assign gain_dn = ({1'b0, gain} < {1'b0, MIN_GAIN} + {1'b0, ATTACK_STEP}) ? MIN_GAIN
                                                                            : gain - ATTACK_STEP;
    assign gain_up = ({1'b0, gain} + {1'b0, RELEASE_STEP} >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY
                                                                                 : gain + RELEASE_STEP;

    // Peak takes priority over every other transition, including hold expiry.
    always_comb begin
        state_n = state;
        gain_n  = gain;
        hold_n  = hold_cnt;
        if (!enable) begin
            state_n = IDLE;
            gain_n  = GAIN_UNITY;
            hold_n  = '0;
        end else if (peak) begin
            state_n = ATTACK;
            gain_n  = gain_dn;
        end else begin
            case (state)
                ATTACK: begin
                    state_n = HOLD;
                    hold_n  = HW'(HOLD_SAMPLES - 1);
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state_n = RELEASE;
                    end else begin
                        hold_n = hold_cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    gain_n = gain_up;
                    if (gain_up == GAIN_UNITY) begin
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gain     <= GAIN_UNITY;
            hold_cnt <= '0;
        end else if (in_valid) begin
            state    <= state_n;
            gain     <= gain_n;
            hold_cnt <= hold_n;
        end
    end

`ifdef LIMITER_HARD_CLIP_EN
    logic clipped;
    logic clip_flag;

    always_comb begin
        limited = scaled;
        clipped = 1'b0;
        if ($signed(scaled) > THRESHOLD) begin
            limited = THRESHOLD;
            clipped = 1'b1;
        end else if ($signed(scaled) < -THRESHOLD) begin
            limited = -THRESHOLD;
            clipped = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_flag <= 1'b0;
        end else if (in_valid) begin
            clip_flag <= enable && clipped;
        end
    end

    assign limiting = (gain != GAIN_UNITY) || clip_flag;
`else
    assign limited  = scaled;
    assign limiting = (gain != GAIN_UNITY);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_sample <= enable ? limited : in_sample;
            end
        end
    end

endmodule

// File: tb/tb_lookahead_limiter.sv
// Self-checking bench for lookahead_limiter against a sample-level reference model.
module tb_lookahead_limiter;

    localparam int DELAY = 16;
    localparam int THR   = 24000;
    localparam int HOLD  = 32;
    localparam int BIG   = 1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        in_valid;
    logic [15:0] in_sample;
    logic        out_valid;
    logic [15:0] out_sample;
    logic [8:0]  gain_out;
    logic        limiting;

    int tests = 0;
    int fails = 0;

    // Reference model state: delay history, gain, samples since last peak.
    int q[$];
    int m_gain;
    int m_since;
    int m_out;
    int m_lim;

    lookahead_limiter #(
        .DELAY_LEN    (DELAY),
        .THRESHOLD    (16'sd24000),
        .ATTACK_STEP  (9'd16),
        .RELEASE_STEP (9'd2),
        .HOLD_SAMPLES (HOLD),
        .MIN_GAIN     (9'd64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .gain_out   (gain_out),
        .limiting   (limiting)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_gain  = 256;
        m_since = BIG;
        m_out   = 0;
        m_lim   = 0;
    endtask

    task automatic send(input int s, input bit en);
        int d;
        int a;
        int r;
        bit clip;
        @(negedge clk);
        in_sample = 16'(s);
        enable    = en;
        in_valid  = 1'b1;

        if (q.size() == DELAY) d = q.pop_front();
        else d = 0;
        q.push_back(s);
        clip = 1'b0;
        if (!en) begin
            r       = s;
            m_gain  = 256;
            m_since = BIG;
        end else begin
            r = (d * m_gain) >>> 8;
`ifdef LIMITER_HARD_CLIP_EN
            if (r > THR) begin
                r = THR;
                clip = 1'b1;
            end else if (r < -THR) begin
                r = -THR;
                clip = 1'b1;
            end
`endif
            a = (s == -32768) ? 32767 : ((s < 0) ? -s : s);
            if (a > THR) begin
                m_gain  = (m_gain - 16 < 64) ? 64 : m_gain - 16;
                m_since = 0;
            end else begin
                if (m_since < BIG) m_since++;
                if (m_since >= HOLD + 2 && m_gain < 256)
                    m_gain = (m_gain + 2 > 256) ? 256 : m_gain + 2;
            end
        end
        m_out = r;
        m_lim = ((m_gain != 256) || clip) ? 1 : 0;

        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("out_valid", out_valid, 1);
        check("out_sample", $signed(out_sample), m_out);
        check("gain_out", gain_out, m_gain);
        check("limiting", limiting, m_lim);
        @(posedge clk);
        #1;
        check("out_valid_drop", out_valid, 0);
        check("out_hold", $signed(out_sample), m_out);
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sample", $signed(out_sample), 0);
        check("rst_gain", gain_out, 256);
        check("rst_limiting", limiting, 0);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state();
        rst = 1'b0;

        // Step 1: fill with traffic, put 8 x 5000 in flight, reset asynchronously mid-cycle.
        for (int i = 0; i < 20; i++) send(int'($urandom_range(0, 4000)) - 2000, 1'b1);
        for (int i = 0; i < 8; i++) send(5000, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_state();
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Step 2: refill must yield 16 zeros; then 1000s, three peaks, delayed peak exit at 208.
        for (int i = 0; i < 16; i++) begin
            send(1000, 1'b1);
            check("refill_zero", $signed(out_sample), 0);
        end
        for (int i = 0; i < 20; i++) send(1000, 1'b1);
        send(30000, 1'b1);
        check("peak1_out", $signed(out_sample), 1000);
        check("peak1_gain", gain_out, 240);
        send(30000, 1'b1);
        check("peak2_gain", gain_out, 224);
        send(30000, 1'b1);
        check("peak3_gain", gain_out, 208);
        for (int i = 0; i < 16; i++) begin
            send(1000, 1'b1);
            if (i == 13) check("peak_exit", $signed(out_sample), 24375);
        end

        // Step 3: sustained peak floors gain, then hold and release back to unity.
        for (int i = 0; i < 40; i++) send(30000, 1'b1);
        check("floor_gain", gain_out, 64);
        check("floor_out", $signed(out_sample), 7500);
        for (int i = 0; i < 33; i++) send(0, 1'b1);
        check("hold_end_gain", gain_out, 64);
        for (int i = 0; i < 95; i++) send(0, 1'b1);
        check("release_near", gain_out, 254);
        send(0, 1'b1);
        check("release_done", gain_out, 256);
        check("release_lim", limiting, 0);

        // Step 4: peak during release at gain 100; threshold equality is not a peak.
        for (int i = 0; i < 15; i++) send(-30000, 1'b1);
        for (int i = 0; i < 51; i++) send(0, 1'b1);
        check("release_100", gain_out, 100);
        send(25000, 1'b1);
        check("reattack_gain", gain_out, 84);
        send(24000, 1'b1);
        check("eq_thr_pos", gain_out, 84);
        send(-24000, 1'b1);
        check("eq_thr_neg", gain_out, 84);

        // Step 5: bypass passes -32768 straight through; limiter sees it as a peak.
        send(-32768, 1'b0);
        check("bypass_out", $signed(out_sample), -32768);
        check("bypass_gain", gain_out, 256);
        send(-32768, 1'b1);
        check("minneg_peak", gain_out, 240);

        // Step 6: delayed 30000 at unity gain after re-enable.
        for (int i = 0; i < 16; i++) send(30000, 1'b0);
        send(0, 1'b1);
`ifdef LIMITER_HARD_CLIP_EN
        check("clip_out", $signed(out_sample), 24000);
        check("clip_lim", limiting, 1);
`else
        check("noclip_out", $signed(out_sample), 30000);
`endif

        // Randomized traffic with bypass toggles and idle gaps.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] r;
            int s;
            bit en;
            r = 16'($urandom);
            case ($urandom_range(0, 3))
                0: s = int'($signed(r));
                1: s = int'($urandom_range(0, 30000)) - 15000;
                2: s = ($urandom_range(0, 1) != 0) ? int'($urandom_range(23990, 24010))
                                                   : -int'($urandom_range(23990, 24010));
                default: s = 0;
            endcase
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            send(s, en);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
